// File: rtl/pipe_arith_pkg.sv
// Shared constants for the pipe_arith3 datapath: default operand width and pipeline depth.
// Pure declarations; no logic, latency or backpressure of its own.
package pipe_arith_pkg;
   localparam int N_DEF   = 10;
   localparam int LATENCY = 3;
endpackage

// File: rtl/pipe_stage_reg.sv
// W-bit pipeline register with synchronous active-high clear.
// Latency 1 cycle; loads every edge, no backpressure.
module pipe_stage_reg #(
   parameter int W = pipe_arith_pkg::N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] nxt,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= nxt;
   end
endmodule

// File: rtl/pipe_arith3.sv
// f = ((a + b) + (c - d)) * d mod 2^N, three registered stages, 3-cycle latency.
// One result per clock, no flow control; in_valid only rides along as out_valid.
module pipe_arith3
   import pipe_arith_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic [N-1:0] d,
   input  logic         in_valid,
   output logic [N-1:0] f,
   output logic         out_valid
);
   logic [N-1:0]   sum_ab, dif_cd, x1, x2, d1;
   logic [N-1:0]   sum_x, x3, d2;
   logic [2*N-1:0] prod;
   logic [N-1:0]   prod_lo;
   logic           v1, v2;

   assign sum_ab = a + b;
   assign dif_cd = c - d;

   pipe_stage_reg #(.W(N)) u_x1 (.clk(clk), .rst(rst), .nxt(sum_ab),   .q(x1));
   pipe_stage_reg #(.W(N)) u_x2 (.clk(clk), .rst(rst), .nxt(dif_cd),   .q(x2));
   pipe_stage_reg #(.W(N)) u_d1 (.clk(clk), .rst(rst), .nxt(d),        .q(d1));
   pipe_stage_reg #(.W(1)) u_v1 (.clk(clk), .rst(rst), .nxt(in_valid), .q(v1));

   assign sum_x = x1 + x2;

   pipe_stage_reg #(.W(N)) u_x3 (.clk(clk), .rst(rst), .nxt(sum_x), .q(x3));
   pipe_stage_reg #(.W(N)) u_d2 (.clk(clk), .rst(rst), .nxt(d1),    .q(d2));
   pipe_stage_reg #(.W(1)) u_v2 (.clk(clk), .rst(rst), .nxt(v1),    .q(v2));

   // d travels with its own operands, so the multiplier is the d captured alongside a/b/c.
   assign prod    = {{N{1'b0}}, x3} * {{N{1'b0}}, d2};
   assign prod_lo = prod[N-1:0];

   pipe_stage_reg #(.W(N)) u_f  (.clk(clk), .rst(rst), .nxt(prod_lo), .q(f));
   pipe_stage_reg #(.W(1)) u_v3 (.clk(clk), .rst(rst), .nxt(v2),      .q(out_valid));
endmodule

// File: tb/tb_pipe_arith3.sv
// Directed bench for pipe_arith3: each step drives one operand set and pushes its expected
// output; the entry launched LATENCY steps earlier is popped and compared against f/out_valid.
module tb_pipe_arith3;
   import pipe_arith_pkg::*;

   localparam int N = N_DEF;

   logic         clk;
   logic         rst;
   logic [N-1:0] a, b, c, d;
   logic         in_valid;
   logic [N-1:0] f;
   logic         out_valid;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic         v;
      logic [N-1:0] f;
      int           id;
   } exp_t;

   exp_t sb[$];

   pipe_arith3 #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .a(a), .b(b), .c(c), .d(d),
      .in_valid(in_valid),
      .f(f), .out_valid(out_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [N-1:0] model(input int xa, input int xb, input int xc, input int xd);
      int s;
      s = (xa + xb + xc + 4096 - xd) % 1024;
      return N'((s * xd) % 1024);
   endfunction

   // One clock step: check the item that is due now, then drive the next operand set.
   task automatic tick(input int xa, input int xb, input int xc, input int xd,
                       input logic xv, input logic xr, input int id);
      exp_t e;
      @(negedge clk);
      if (sb.size() == LATENCY) begin
         e = sb.pop_front();
         n_cmp++;
         assert (out_valid === e.v) else begin
            n_bad++;
            $error("FAIL out_valid item %0d: observed %b expected %b", e.id, out_valid, e.v);
         end
         n_cmp++;
         assert (f === e.f) else begin
            n_bad++;
            $error("FAIL f item %0d: observed %0d expected %0d", e.id, f, e.f);
         end
      end
      a        = xa[N-1:0];
      b        = xb[N-1:0];
      c        = xc[N-1:0];
      d        = xd[N-1:0];
      in_valid = xv;
      rst      = xr;
      if (xr) begin
         // The reset edge clears every stage, so everything still due reads back as zero.
         sb.delete();
         for (int i = 0; i < LATENCY; i++) sb.push_back('{v: 1'b0, f: '0, id: id});
      end else begin
         sb.push_back('{v: xv, f: model(xa, xb, xc, xd), id: id});
      end
   endtask

   initial begin
      rst = 1'b1; a = '0; b = '0; c = '0; d = '0; in_valid = 1'b0;

      // reset held for two edges with live-looking inputs
      tick(7, 9, 3, 2, 1'b1, 1'b1, 0);
      tick(500, 400, 300, 200, 1'b1, 1'b1, 1);
      // release with idle zero inputs
      tick(0, 0, 0, 0, 1'b0, 1'b0, 2);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 3);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 4);

      // back-to-back stream: 60, 42, 112 (subtract wrap), 62
      tick(5, 12, 6, 3, 1'b1, 1'b0, 10);
      tick(10, 8, 5, 2, 1'b1, 1'b0, 11);
      tick(20, 11, 1, 4, 1'b1, 1'b0, 12);
      tick(15, 10, 8, 2, 1'b1, 1'b0, 13);

      // add overflow -> 75, multiply overflow -> 176
      tick(1000, 100, 0, 1, 1'b1, 1'b0, 20);
      tick(300, 0, 4, 4, 1'b1, 1'b0, 21);
      tick(1023, 1023, 1023, 1023, 1'b1, 1'b0, 22);

      // valid bubbles
      tick(3, 4, 5, 6, 1'b1, 1'b0, 30);
      tick(9, 9, 9, 9, 1'b0, 1'b0, 31);
      tick(100, 200, 50, 7, 1'b1, 1'b0, 32);
      tick(1, 2, 3, 4, 1'b0, 1'b0, 33);
      tick(511, 511, 1000, 999, 1'b1, 1'b0, 34);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 35);

      // mid-stream reset with items in flight, then one fresh item
      tick(5, 12, 6, 3, 1'b1, 1'b0, 40);
      tick(10, 8, 5, 2, 1'b1, 1'b0, 41);
      tick(20, 11, 1, 4, 1'b1, 1'b0, 42);
      tick(15, 10, 8, 2, 1'b1, 1'b1, 43);
      tick(5, 12, 6, 3, 1'b1, 1'b0, 44);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 45);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 46);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 47);
      tick(0, 0, 0, 0, 1'b0, 1'b0, 48);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
